uart_prog_loader: RTL and testbench

Parametrised successor of the UART instruction collector. It takes a framed program image from a byte-stream UART receiver and assembles little-endian words of DATA_W bits. It writes each word to instruction memory through a valid/ready port, appends NOP padding and a HALT word, and verifies an XOR checksum. It sits between the UART RX block and instruction memory, and raises start to release the core only when the frame is good.

---
 rtl/uart_prog_loader.sv | 198 +++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program loader: collects a length-prefixed byte frame into DATA_W-bit little-endian
// words, writes them to instruction memory, appends NOP padding and a HALT word, checks the XOR sum.
module uart_prog_loader #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                PAD_WORDS = 6,
    parameter logic [DATA_W-1:0] NOP_WORD  = 'h13,
    parameter logic [DATA_W-1:0] HALT_WORD = '1,
    parameter int unsigned       TIMEOUT   = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic              start_o,
    output logic              busy_o,
    output logic [2:0]        error_o,
    output logic [31:0]       byte_count_o
);
    localparam int WB = DATA_W / 8;
    localparam int LW = $clog2(WB);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, PAD, HALT, DONE, FAIL} state_t;

    state_t            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        len_idx_q, len_idx_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [3:0]        pad_q, pad_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [ADDR_W-1:0] naddr_q, naddr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        err_q, err_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;

    logic              in_frame, out_free, timeout, last_byte, load;
    logic [DATA_W-1:0] word_w, load_word;

    assign in_frame  = state_q inside {LEN, PAYLOAD, CHECK};
    // The output register can take a new word if empty or being accepted this cycle.
    assign out_free  = !wr_valid_q || wr_ready_i;
    assign timeout   = (TIMEOUT != 0) && in_frame && !rx_valid_i && (idle_q == TW'(TIMEOUT - 1));
    assign last_byte = (cnt_q + 32'd1) == len_q;
    assign word_w    = asm_q | (DATA_W'(rx_byte_i) << {lane_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        len_idx_d  = len_idx_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        pad_d      = pad_q;
        naddr_d    = naddr_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        err_d      = err_q;
        start_d    = start_q;
        load       = 1'b0;
        load_word  = '0;
        idle_d     = '0;
        if (in_frame && !rx_valid_i) idle_d = idle_q + 1'b1;
        if (wr_valid_q && wr_ready_i) wr_valid_d = 1'b0;

        case (state_q)
            IDLE: if (rx_valid_i) begin
                len_d     = {24'h0, rx_byte_i};
                len_idx_d = 2'd1;
                state_d   = LEN;
            end
            LEN: if (rx_valid_i) begin
                len_d[8*len_idx_q +: 8] = rx_byte_i;
                len_idx_d = len_idx_q + 2'd1;
                if (len_idx_q == 2'd3)
                    state_d = ({rx_byte_i, len_q[23:0]} == 32'd0) ? CHECK : PAYLOAD;
            end else if (timeout) begin
                err_d[2] = 1'b1;
                state_d  = FAIL;
            end
            PAYLOAD: if (rx_valid_i) begin
                csum_d = csum_q ^ rx_byte_i;
                cnt_d  = cnt_q + 32'd1;
                if (lane_q == LW'(WB - 1) || last_byte) begin
                    asm_d  = '0;
                    lane_d = '0;
                    if (out_free) begin
                        load      = 1'b1;
                        load_word = word_w;
                        if (last_byte) state_d = CHECK;
                    end else begin
                        err_d[1] = 1'b1;
                        state_d  = FAIL;
                    end
                end else begin
                    asm_d  = word_w;
                    lane_d = lane_q + 1'b1;
                end
            end else if (timeout) begin
                err_d[2] = 1'b1;
                state_d  = FAIL;
            end
            CHECK: if (rx_valid_i) begin
                if (rx_byte_i != csum_q) err_d[0] = 1'b1;
                state_d = PAD;
            end else if (timeout) begin
                err_d[2] = 1'b1;
                state_d  = FAIL;
            end
            PAD: begin
                if (rx_valid_i) err_d[1] = 1'b1;
                if (out_free) begin
                    load = 1'b1;
                    if (pad_q == 4'(PAD_WORDS)) begin
                        load_word = HALT_WORD;
                        state_d   = HALT;
                    end else begin
                        load_word = NOP_WORD;
                        pad_d     = pad_q + 4'd1;
                    end
                end
            end
            HALT: begin
                if (rx_valid_i) err_d[1] = 1'b1;
                if (wr_valid_q && wr_ready_i) state_d = (err_d == 3'b000) ? DONE : FAIL;
            end
            DONE: start_d = 1'b1;
            FAIL: ;
        endcase

        if (load) begin
            wr_valid_d = 1'b1;
            wr_data_d  = load_word;
            wr_addr_d  = naddr_q;
            naddr_d    = naddr_q + ADDR_W'(WB);
        end
        busy_d = !(state_d inside {IDLE, DONE, FAIL});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            len_idx_q  <= '0;
            lane_q     <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            cnt_q      <= '0;
            pad_q      <= '0;
            idle_q     <= '0;
            naddr_q    <= BASE_ADDR;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= BASE_ADDR;
            err_q      <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            len_idx_q  <= len_idx_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            cnt_q      <= cnt_d;
            pad_q      <= pad_d;
            idle_q     <= idle_d;
            naddr_q    <= naddr_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            err_q      <= err_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_data_o    = wr_data_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_valid_o   = wr_valid_q;
    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign error_o      = err_q;
    assign byte_count_o = cnt_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a 32-bit and a 16-bit instance share one byte stream and are
// checked against a byte-level model of the expected memory write sequence.
module tb_uart_prog_loader;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0, wr_ready = 1'b1;
    logic [31:0] wd0, wa0, bc0, wa1, bc1;
    logic [15:0] wd1;
    logic        wv0, st0, bz0, wv1, st1, bz1;
    logic [2:0]  er0, er1;
    int          n_chk = 0, n_fail = 0;
    logic [95:0] cap0[$], cap1[$], exp0[$], exp1[$];
    logic [7:0]  pl[$];
    logic [95:0] hold0, hold1;
    logic        pend0 = 1'b0, pend1 = 1'b0;

    uart_prog_loader #(.DATA_W(32), .TIMEOUT(100)) u32 (
        .clk(clk), .rst(rst), .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
        .wr_data_o(wd0), .wr_addr_o(wa0), .wr_valid_o(wv0), .wr_ready_i(wr_ready),
        .start_o(st0), .busy_o(bz0), .error_o(er0), .byte_count_o(bc0));

    uart_prog_loader #(.DATA_W(16), .TIMEOUT(100)) u16 (
        .clk(clk), .rst(rst), .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
        .wr_data_o(wd1), .wr_addr_o(wa1), .wr_valid_o(wv1), .wr_ready_i(wr_ready),
        .start_o(st1), .busy_o(bz1), .error_o(er1), .byte_count_o(bc1));

    always #5 clk = ~clk;

    // Capture handshakes and require a stalled word to stay put until accepted.
    always @(negedge clk) begin
        if (pend0) begin
            n_chk++;
            if (!wv0 || {wa0, 32'h0, wd0} !== hold0) begin
                n_fail++;
                $display("FAIL hold32: got v=%0b %h want v=1 %h", wv0, {wa0, 32'h0, wd0}, hold0);
            end
        end
        if (pend1) begin
            n_chk++;
            if (!wv1 || {wa1, 48'h0, wd1} !== hold1) begin
                n_fail++;
                $display("FAIL hold16: got v=%0b %h want v=1 %h", wv1, {wa1, 48'h0, wd1}, hold1);
            end
        end
        if (wv0 && wr_ready) cap0.push_back({wa0, 32'h0, wd0});
        if (wv1 && wr_ready) cap1.push_back({wa1, 48'h0, wd1});
        pend0 <= wv0 && !wr_ready && !rst;
        pend1 <= wv1 && !wr_ready && !rst;
        hold0 <= {wa0, 32'h0, wd0};
        hold1 <= {wa1, 48'h0, wd1};
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] l);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [7:0] chk, input int maxgap);
        send_len(pl.size());
        for (int i = 0; i < pl.size(); i++) begin tick($urandom_range(maxgap, 0)); send_byte(pl[i]); end
        tick($urandom_range(maxgap, 0));
        send_byte(chk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_ready = 1'b1; tick(2); rst = 1'b0;
        cap0.delete(); cap1.delete(); exp0.delete(); exp1.delete();
    endtask

    function automatic logic [7:0] pl_xor();
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    // Expected writes: nb payload bytes cut into little-endian words (partial word flushed
    // if requested), then optionally six NOPs and the all-ones HALT word.
    task automatic build(input int u, input int nb, input bit flush, input bit pads);
        int wb = (u == 0) ? 4 : 2;
        int nw = flush ? (nb + wb - 1) / wb : nb / wb;
        logic [63:0] w;
        logic [31:0] a = 32'd0;
        for (int k = 0; k < nw; k++) begin
            w = 64'h0;
            for (int j = 0; j < wb; j++) if (k*wb + j < nb) w |= 64'(pl[k*wb + j]) << (8*j);
            if (u == 0) exp0.push_back({a, w}); else exp1.push_back({a, w});
            a += wb;
        end
        if (pads) begin
            for (int p = 0; p < 7; p++) begin
                w = (p == 6) ? (64'h1 << (8*wb)) - 64'h1 : 64'h13;
                if (u == 0) exp0.push_back({a, w}); else exp1.push_back({a, w});
                a += wb;
            end
        end
    endtask

    task automatic settle(input bit rnd_ready, input string nm);
        int n = 0;
        while ((bz0 || bz1 || wv0 || wv1) && n < 2000) begin
            if (rnd_ready) wr_ready = ($urandom_range(1, 0) == 1);
            tick(1);
            n++;
        end
        wr_ready = 1'b1;
        n_chk++;
        if (n >= 2000) begin n_fail++; $display("FAIL %s settle: still busy after %0d cycles", nm, n); end
        tick(3);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({wv0, wd0, wa0, st0, bz0, er0, bc0} !== 71'h0 || {wv1, wd1, wa1, st1, bz1, er1, bc1} !== 55'h0) begin
            n_fail++;
            $display("FAIL reset: got %h / %h want 0", {wv0, wd0, wa0, st0, bz0, er0, bc0}, {wv1, wd1, wa1, st1, bz1, er1, bc1});
        end
    endtask

    task automatic test_frames();
        logic [63:0] t1;
        logic [7:0]  chk;
        logic [2:0]  ee;
        int          len;
        for (int c = 0; c < 8; c++) begin
            do_reset();
            pl.delete();
            t1 = 64'h0010_0093_0000_0013;
            case (c)
                0, 2: for (int i = 0; i < 8; i++) pl.push_back(t1[8*i +: 8]);
                1: for (int i = 0; i < 6; i++) pl.push_back(8'(i + 1));
                3: ;
                default: begin
                    len = (c == 7) ? $urandom_range(300, 250) : $urandom_range(20, 1);
                    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(255, 0)));
                end
            endcase
            chk = (c == 0) ? 8'h83 : (c == 2) ? 8'h84 : (c == 1) ? 8'h07 : pl_xor();
            if (c == 5) chk ^= 8'($urandom_range(255, 1));
            ee = (chk != pl_xor()) ? 3'b001 : 3'b000;
            build(0, pl.size(), 1'b1, 1'b1);
            build(1, pl.size(), 1'b1, 1'b1);
            send_frame(chk, (c >= 4) ? 3 : 0);
            settle(c >= 4, "frame");
            send_byte(8'hA5); send_byte(8'h5A); tick(3);
            n_chk++;
            if (cap0.size() != exp0.size() || cap1.size() != exp1.size()) begin
                n_fail++;
                $display("FAIL frame%0d wcount: got %0d/%0d want %0d/%0d", c, cap0.size(), cap1.size(), exp0.size(), exp1.size());
            end
            foreach (exp0[i]) if (i < cap0.size()) begin
                n_chk++;
                if (cap0[i] !== exp0[i]) begin n_fail++; $display("FAIL frame%0d w32[%0d]: got %h want %h", c, i, cap0[i], exp0[i]); end
            end
            foreach (exp1[i]) if (i < cap1.size()) begin
                n_chk++;
                if (cap1[i] !== exp1[i]) begin n_fail++; $display("FAIL frame%0d w16[%0d]: got %h want %h", c, i, cap1[i], exp1[i]); end
            end
            n_chk++;
            if ({er0, st0, bz0, bc0} !== {ee, ee == 3'b000, 1'b0, 32'(pl.size())} ||
                {er1, st1, bz1, bc1} !== {ee, ee == 3'b000, 1'b0, 32'(pl.size())}) begin
                n_fail++;
                $display("FAIL frame%0d status: got err=%b/%b start=%b/%b busy=%b/%b cnt=%0d/%0d want err=%b start=%b busy=0 cnt=%0d",
                         c, er0, er1, st0, st1, bz0, bz1, bc0, bc1, ee, ee == 3'b000, pl.size());
            end
        end
    endtask

    task automatic test_pad_rx();
        do_reset();
        pl.delete();
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom_range(255, 0)));
        build(0, 6, 1'b1, 1'b1);
        build(1, 6, 1'b1, 1'b1);
        send_frame(pl_xor(), 0);
        wr_ready = 1'b0; tick(2);
        send_byte(8'h77); tick(2);
        settle(1'b1, "padrx");
        n_chk++;
        if (cap0.size() != exp0.size() || cap1.size() != exp1.size()) begin
            n_fail++;
            $display("FAIL padrx wcount: got %0d/%0d want %0d/%0d", cap0.size(), cap1.size(), exp0.size(), exp1.size());
        end
        foreach (exp0[i]) if (i < cap0.size()) begin
            n_chk++;
            if (cap0[i] !== exp0[i]) begin n_fail++; $display("FAIL padrx w32[%0d]: got %h want %h", i, cap0[i], exp0[i]); end
        end
        foreach (exp1[i]) if (i < cap1.size()) begin
            n_chk++;
            if (cap1[i] !== exp1[i]) begin n_fail++; $display("FAIL padrx w16[%0d]: got %h want %h", i, cap1[i], exp1[i]); end
        end
        n_chk++;
        if ({er0, st0, er1, st1} !== {3'b010, 1'b0, 3'b010, 1'b0}) begin
            n_fail++;
            $display("FAIL padrx status: got err=%b/%b start=%b/%b want err=010 start=0", er0, er1, st0, st1);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom_range(255, 0)));
        build(0, 4, 1'b0, 1'b0);
        build(1, 2, 1'b0, 1'b0);
        wr_ready = 1'b0;
        send_frame(pl_xor(), 0);
        tick(27);
        wr_ready = 1'b1;
        settle(1'b0, "overflow");
        n_chk++;
        if (cap0.size() != 1 || cap1.size() != 1) begin
            n_fail++;
            $display("FAIL overflow wcount: got %0d/%0d want 1/1", cap0.size(), cap1.size());
        end else begin
            n_chk++;
            if (cap0[0] !== exp0[0] || cap1[0] !== exp1[0]) begin
                n_fail++;
                $display("FAIL overflow word0: got %h/%h want %h/%h", cap0[0], cap1[0], exp0[0], exp1[0]);
            end
        end
        n_chk++;
        if ({er0, st0, bz0, bc0, er1, st1, bz1, bc1} !== {3'b010, 2'b00, 32'd8, 3'b010, 2'b00, 32'd4}) begin
            n_fail++;
            $display("FAIL overflow status: got err=%b/%b start=%b/%b busy=%b/%b cnt=%0d/%0d want err=010 start=0 busy=0 cnt=8/4",
                     er0, er1, st0, st1, bz0, bz1, bc0, bc1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        pl.delete();
        for (int i = 0; i < 2; i++) pl.push_back(8'($urandom_range(255, 0)));
        build(0, 2, 1'b0, 1'b0);
        build(1, 2, 1'b0, 1'b0);
        send_len(32'd8);
        send_byte(pl[0]); send_byte(pl[1]);
        tick(90);
        n_chk++;
        if ({bz0, er0, bz1, er1} !== {1'b1, 3'b000, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL timeout early: got busy=%b/%b err=%b/%b want busy=1 err=000", bz0, bz1, er0, er1);
        end
        tick(20);
        settle(1'b0, "timeout");
        n_chk++;
        if (cap0.size() != exp0.size() || cap1.size() != exp1.size()) begin
            n_fail++;
            $display("FAIL timeout wcount: got %0d/%0d want %0d/%0d", cap0.size(), cap1.size(), exp0.size(), exp1.size());
        end
        foreach (exp1[i]) if (i < cap1.size()) begin
            n_chk++;
            if (cap1[i] !== exp1[i]) begin n_fail++; $display("FAIL timeout w16[%0d]: got %h want %h", i, cap1[i], exp1[i]); end
        end
        n_chk++;
        if ({er0, st0, bz0, bc0, er1, st1, bz1, bc1} !== {3'b100, 2'b00, 32'd2, 3'b100, 2'b00, 32'd2}) begin
            n_fail++;
            $display("FAIL timeout status: got err=%b/%b start=%b/%b busy=%b/%b cnt=%0d/%0d want err=100 start=0 busy=0 cnt=2",
                     er0, er1, st0, st1, bz0, bz1, bc0, bc1);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        wr_ready = 1'b0;
        send_len(32'd8);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(255, 0)));
        tick(1);
        rst = 1'b1; tick(1);
        n_chk++;
        if ({wv0, wd0, wa0, st0, bz0, er0, bc0} !== 71'h0 || {wv1, wd1, wa1, st1, bz1, er1, bc1} !== 55'h0) begin
            n_fail++;
            $display("FAIL midreset: got %h / %h want 0", {wv0, wd0, wa0, st0, bz0, er0, bc0}, {wv1, wd1, wa1, st1, bz1, er1, bc1});
        end
        rst = 1'b0; wr_ready = 1'b1;
        tick(20);
        n_chk++;
        if (cap0.size() != 0 || cap1.size() != 0 || bz0 || bz1) begin
            n_fail++;
            $display("FAIL midreset after: got writes=%0d/%0d busy=%b/%b want 0 writes busy=0", cap0.size(), cap1.size(), bz0, bz1);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_pad_rx();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
